// File: rtl/sn_api_arbiter.sv
// sn_api_arbiter: round-robin API grant arbiter per transmit window; SN_API_ARB_STATS_EN adds window statistics
module sn_api_arbiter #(
  parameter int P_NUM_NEURONS = 100,
  parameter int P_NUM_OUTPUTS = 3,
  parameter int P_NUM_REQ = P_NUM_NEURONS - P_NUM_OUTPUTS,
  parameter int P_IDX_BW = $clog2(P_NUM_NEURONS - P_NUM_OUTPUTS + 1),
  parameter int P_MAX_GRANTS = P_NUM_REQ
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 nc_transmit,
  input  logic [P_NUM_REQ-1:0] api_pending,
  input  logic [P_IDX_BW-1:0]  api_bus,
  output logic [P_NUM_REQ-1:0] api_granted,
  output logic                 api_vld,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_overflow
`ifdef SN_API_ARB_STATS_EN
  ,
  output logic [P_IDX_BW:0]    stat_grants,
  output logic [P_IDX_BW:0]    stat_max_grants
`endif
);
  localparam int CW = P_IDX_BW + 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_GRANT = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;
  localparam logic [CW-1:0] MAXG = CW'(P_MAX_GRANTS);
  logic [1:0] state;
  logic [P_IDX_BW-1:0] rr_ptr, ptr_nxt;
  logic [CW-1:0] grant_cnt;
  logic [P_NUM_REQ-1:0] eligible, hi, sel, onehot;
  // Prefer requesters at or above rr_ptr; fall back to the lowest one to wrap around.
  always_comb begin
    eligible = api_pending & ~api_granted;
    hi = eligible & ~((P_NUM_REQ'(1) << rr_ptr) - P_NUM_REQ'(1));
    sel = |hi ? hi : eligible;
    onehot = sel & (~sel + P_NUM_REQ'(1));
    ptr_nxt = rr_ptr;
    for (int i = 0; i < P_NUM_REQ; i++)
      if (onehot[i]) ptr_nxt = (i == P_NUM_REQ - 1) ? '0 : P_IDX_BW'(i + 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      api_granted <= '0;
      api_vld <= 1'b0;
      tx_overflow <= 1'b0;
      rr_ptr <= '0;
      grant_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (nc_transmit) begin
          state <= S_GRANT;
          tx_overflow <= 1'b0;
          grant_cnt <= '0;
        end
        S_GRANT: if (eligible == '0) begin
          api_granted <= '0;
          api_vld <= 1'b0;
          state <= S_DRAIN;
        end else if (grant_cnt < MAXG) begin
          api_granted <= onehot;
          api_vld <= 1'b1;
          rr_ptr <= ptr_nxt;
          grant_cnt <= grant_cnt + 1'b1;
        end else begin
          api_granted <= '0;
          api_vld <= 1'b0;
          tx_overflow <= 1'b1;
          state <= S_DRAIN;
        end
        S_DRAIN: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  assign tx_busy = state != S_IDLE;
  assign tx_done = state == S_DONE;
`ifdef SN_API_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_grants <= '0;
      stat_max_grants <= '0;
    end else if (state == S_DONE) begin
      stat_grants <= grant_cnt;
      if (grant_cnt > stat_max_grants) stat_max_grants <= grant_cnt;
    end
`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (rst_n && api_vld)
      assert (api_bus != '0 && !$isunknown(api_bus)) else $error("api_bus invalid while api_vld");
`endif
`else
  logic unused_bus;
  assign unused_bus = ^api_bus;
`endif
endmodule
